// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: constants and types shared by the fetch stage, IF/ID and the
// hazard unit.
//   fetch_state_e : fetch FSM states (FETCH, SQUASH, HALT)
//   HALT_WORD     : all-ones instruction word that ends the program
//   NOP_WORD      : bubble inserted into IF/ID when no valid instruction
package if_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALT   = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the PC, drives the instruction
// memory port and presents {instruction, PC+4} to the IF/ID register.
//   clk, reset         : clock, synchronous active-low reset
//   pc_write           : hazard-unit advance enable (0 = stall)
//   branch_taken/jump  : redirect requests (jump has priority) with targets
//   imem_req/imem_addr : fetch request and address (= PC)
//   imem_ready/rdata   : memory response, valid in the same cycle
//   inst_out/pcplus_out/inst_valid : IF/ID payload (combinational)
//   halted             : fetch stopped on the halt word until reset
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pcplus_out,
  output logic        inst_valid,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;   // redirect target held while a fetch is in flight

  logic        redir;
  logic [31:0] target;
  logic        accept;

  assign redir  = jump | branch_taken;
  assign target = jump ? jump_target : branch_target;

  assign imem_req  = reset & (state_q != HALT);
  assign imem_addr = pc_q;

  // Gating with imem_req keeps a response seen while reset is asserted
  // from ever being presented as an instruction.
  assign accept     = imem_req & (state_q == FETCH) & imem_ready & pc_write & ~redir;
  assign inst_valid = accept;
  assign inst_out   = accept ? imem_rdata : NOP_WORD;
  assign pcplus_out = pc_q + 32'd4;
  assign halted     = (state_q == HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      FETCH: begin
        if (redir) begin
          if (imem_ready) begin
            pc_d = target;
          end else begin
            // The in-flight access must complete at the current address;
            // its data is discarded in SQUASH.
            tgt_d   = target;
            state_d = SQUASH;
          end
        end else if (accept) begin
          if (imem_rdata == HALT_WORD) state_d = HALT;
          else                         pc_d    = pc_q + 32'd4;
        end
      end
      SQUASH: begin
        if (redir) tgt_d = target;
        if (imem_ready) begin
          pc_d    = redir ? target : tgt_q;
          state_d = FETCH;
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, pc_write, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, inst_valid, halted;
  logic [31:0] imem_addr, inst_out, pcplus_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pcplus_out(pcplus_out),
    .inst_valid(inst_valid), .halted(halted)
  );

  // Reference model: architectural PC, halted flag, and an optional pending
  // redirect that is waiting for the in-flight access to finish.
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_pend;
  logic [31:0] m_ptgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit pw, input bit rdy, input logic [31:0] rd,
                       input bit br, input logic [31:0] bt, input bit j, input logic [31:0] jt);
    @(negedge clk);
    reset = rst; pc_write = pw; imem_ready = rdy; imem_rdata = rd;
    branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    #1;
  endtask

  // Compare every output against the model, then let the edge happen and
  // advance the model with the same inputs.
  task automatic tick();
    bit          rd_ok, vld;
    logic [31:0] tgt;
    rd_ok = (branch_taken | jump);
    tgt   = jump ? jump_target : branch_target;
    vld   = reset && !m_halt && !m_pend && imem_ready && pc_write && !rd_ok;
    chk("req",    {31'b0, imem_req}, {31'b0, reset && !m_halt});
    chk("addr",   imem_addr, m_pc);
    chk("valid",  {31'b0, inst_valid}, {31'b0, vld});
    chk("inst",   inst_out, vld ? imem_rdata : 32'h0);
    chk("pcplus", pcplus_out, m_pc + 32'd4);
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    @(posedge clk);
    if (!reset) begin
      m_pc = RPC; m_halt = 0; m_pend = 0;
    end else if (m_halt) begin
      // frozen until reset
    end else if (m_pend) begin
      if (rd_ok) m_ptgt = tgt;
      if (imem_ready) begin m_pc = m_ptgt; m_pend = 0; end
    end else if (rd_ok) begin
      if (imem_ready) m_pc = tgt;
      else begin m_pend = 1; m_ptgt = tgt; end
    end else if (vld) begin
      if (imem_rdata == 32'hFFFF_FFFF) m_halt = 1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    // First reset edge brings the DUT out of X; model is set to match.
    drive(0, 1, 1, 32'h13, 0, 0, 0, 0);
    @(posedge clk);
    m_pc = RPC; m_halt = 0; m_pend = 0; m_ptgt = 0;

    // Reset held: no request, NOP, PC+4 from RESET_PC.
    drive(0, 1, 1, 32'h13, 0, 0, 0, 0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pcplus", pcplus_out, RPC + 32'd4);
    chk("rst_inst", inst_out, 32'h0);
    tick();

    // Streaming with single-cycle memory.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 32'h1000 + i, 0, 0, 0, 0);
      chk("seq_addr", imem_addr, 32'(i * 4));
      chk("seq_pcplus", pcplus_out, 32'(i * 4 + 4));
      chk("seq_valid", {31'b0, inst_valid}, 32'd1);
      tick();
    end

    // Two-cycle stall at PC=16.
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 32'h2000, 0, 0, 0, 0);
      chk("stall_addr", imem_addr, 32'd16);
      chk("stall_valid", {31'b0, inst_valid}, 32'd0);
      tick();
    end
    drive(1, 1, 1, 32'h2000, 0, 0, 0, 0);
    chk("stall_rel", imem_addr, 32'd16);
    tick();
    drive(1, 1, 0, 32'h2004, 0, 0, 0, 0);
    chk("stall_next", imem_addr, 32'd20);
    tick();

    // Memory wait with a branch arriving mid-wait.
    drive(1, 1, 0, 32'h3000, 1, 32'h40, 0, 0);
    tick();
    drive(1, 1, 0, 32'h3000, 0, 0, 0, 0);
    chk("wait_hold", imem_addr, 32'd20);
    tick();
    drive(1, 1, 1, 32'h3000, 0, 0, 0, 0);
    chk("squash_drop", {31'b0, inst_valid}, 32'd0);
    chk("squash_addr", imem_addr, 32'd20);
    tick();
    drive(1, 1, 1, 32'h3004, 0, 0, 0, 0);
    chk("redir_tgt", imem_addr, 32'h40);
    tick();

    // Jump beats branch in the same cycle.
    drive(1, 1, 1, 32'h4000, 1, 32'h80, 1, 32'h100);
    chk("jb_valid", {31'b0, inst_valid}, 32'd0);
    tick();

    // Halt word at 0x100: passed once, then halted and deaf to branches.
    drive(1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("jmp_addr", imem_addr, 32'h100);
    chk("halt_pass", inst_out, 32'hFFFF_FFFF);
    tick();
    drive(1, 1, 1, 32'h13, 1, 32'h80, 0, 0);
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    tick();
    drive(1, 1, 1, 32'h13, 0, 0, 0, 0);
    chk("halt_ign", imem_addr, 32'h100);
    tick();

    // Reset out of HALT, enter SQUASH, then reset with a stale response.
    drive(0, 1, 1, 32'h13, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 32'h13, 1, 32'h200, 0, 0);
    tick();
    drive(0, 1, 1, 32'h13, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 32'h13, 0, 0, 0, 0);
    chk("sqrst_addr", imem_addr, RPC);
    chk("sqrst_halt", {31'b0, halted}, 32'd0);
    tick();
    drive(1, 1, 1, 32'h13, 0, 0, 0, 0);
    chk("sqrst_adv", imem_addr, RPC + 32'd4);
    tick();

    // PC wrap at the top of the address space.
    drive(1, 1, 1, 32'h13, 0, 0, 1, 32'hFFFF_FFFC);
    tick();
    drive(1, 1, 1, 32'h13, 0, 0, 0, 0);
    chk("wrap_pcplus", pcplus_out, 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rd;
      rd = ($urandom_range(0, 24) == 0) ? 32'hFFFF_FFFF : $urandom;
      drive(($urandom_range(0, 40) != 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 2) != 0),
            rd,
            ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 11) == 0), $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that owns the program counter and drives the instruction-memory port. It feeds the IF/ID pipeline register, supplying the fetched word and PC+4 each cycle. It handles hazard stalls, branch/jump redirects (including redirects that arrive while a memory access is outstanding) and program-end halt on the all-ones word.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low
- pc_write  in  1  hazard-unit advance enable; 0 = stall, PC held
- branch_taken  in  1  redirect to branch_target
- branch_target  in  32  branch destination (byte address)
- jump  in  1  redirect to jump_target; priority over branch_taken
- jump_target  in  32  jump destination (byte address)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= PC)
- imem_ready  in  1  memory response; imem_rdata valid in the same cycle while imem_req=1
- imem_rdata  in  32  fetched word
- inst_out  out  32  instruction to IF/ID; 32'h0 (NOP) when inst_valid=0
- pcplus_out  out  32  PC+4 to IF/ID
- inst_valid  out  1  inst_out is a real, on-path instruction
- halted  out  1  fetch stopped on halt word

## Operation
- States: FETCH, SQUASH, HALT. Reset -> FETCH, PC=RESET_PC, redirect buffer cleared.
- Redirect: redir = jump | branch_taken; target = jump ? jump_target : branch_target.
- imem_req = reset & (state != HALT); imem_addr = PC. While imem_req=1 and imem_ready=0, imem_addr is held stable.
- accept = (state == FETCH) & imem_ready & pc_write & ~redir.
- FETCH:
  - redir & imem_ready: PC <= target; inst_valid=0; stay FETCH.
  - redir & ~imem_ready: buffer target; -> SQUASH; PC unchanged.
  - accept & imem_rdata==32'hFFFF_FFFF: inst_valid=1 and the halt word is passed through once; -> HALT; PC unchanged.
  - accept, other data: inst_valid=1; PC <= PC+4.
  - imem_ready & ~pc_write: inst_valid=0; PC held; same address refetched next cycle.
  - ~imem_ready: inst_valid=0; wait.
- SQUASH: inst_valid=0 always.
  - A new redir overwrites the buffered target; latest wins.
  - On imem_ready: data dropped; PC <= buffered target, or the current-cycle target if redir; -> FETCH.
- HALT: imem_req=0; inst_valid=0; halted=1; redirects ignored. Exit only via reset.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. PC low two bits are not checked.

## Timing
- Reset values (cycle after reset low sampled): PC=RESET_PC, state FETCH, imem_req=0 while reset=0, inst_valid=0, inst_out=0, halted=0, pcplus_out=RESET_PC+4.
- inst_out, inst_valid and pcplus_out are combinational from imem_rdata, PC and state. IF/ID registers them at the same edge the PC advances; zero added latency.
- Single-cycle memory (imem_ready tied 1): one instruction per cycle, PC sequence RESET_PC, +4, +8, …
- Redirect to first target fetch: next cycle in FETCH; in SQUASH, the cycle after the pending imem_ready.
- Simultaneous redir and halt word: redirect wins; HALT not entered.
- Reset low mid-operation (any state, including SQUASH or HALT): aborts at that edge; the pending response is ignored.

## Structure
- Shared package: state enum (FETCH, SQUASH, HALT), HALT_WORD=32'hFFFF_FFFF, NOP_WORD=32'h0000_0000. The same constants are used by IF/ID and the hazard unit.
- Single module. PC register, redirect buffer and FSM are inline; no sub-module.

## Test plan
- Reset, imem_ready=1, pc_write=1, RESET_PC=0: imem_addr 0,4,8,12 on consecutive cycles; pcplus_out 4,8,12,16; inst_valid=1 each cycle.
- pc_write=0 for 2 cycles at PC=8: imem_addr stays 8; inst_valid=0; PC resumes 12 after release.
- imem_ready low 3 cycles at PC=0x10, branch_taken pulse (target 0x40) in wait cycle 2: address held 0x10 until ready; data dropped; next fetch at 0x40.
- Same-cycle jump (0x100) and branch (0x80) with imem_ready=1: next imem_addr=0x100; inst_valid=0 that cycle.
- imem_rdata=32'hFFFF_FFFF at PC=0x20: inst_valid=1 with inst_out=all-ones for one cycle; then halted=1, imem_req=0. A later branch_taken is ignored.
- Reset low while in SQUASH: next cycle imem_addr=RESET_PC, state FETCH, halted=0; the stale imem_ready is ignored.
